// File: rtl/toggle_hs_receiver_if.sv
// Bundle of the toggle-handshake request side and the valid/ready output side.
// The receiver takes the slave modport; the sender/consumer environment takes master.
interface toggle_hs_receiver_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             req_toggle;
    logic [WIDTH-1:0] req_data;
    logic             ack_toggle;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             proto_err;

    modport master (
        output req_toggle, req_data, out_ready,
        input  ack_toggle, out_data, out_valid, count, proto_err
    );

    modport slave (
        input  req_toggle, req_data, out_ready,
        output ack_toggle, out_data, out_valid, count, proto_err
    );
endinterface

// File: rtl/toggle_hs_receiver.sv
// Two-phase (toggle) handshake receiver: acks each accepted word by flipping ack_toggle
// and buffers the words in a small FIFO drained through a valid/ready port.
module toggle_hs_receiver #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    toggle_hs_receiver_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ack_q;
    logic             req_prev_q;
    logic             pend_q;
    logic             err_q;

    logic pending, pop, accept, full, out_valid;

    always_comb begin
        out_valid = (count_q != '0);
        full      = (count_q == CW'(DEPTH));
        pending   = (bus.req_toggle != req_prev_q);
        pop       = ~rst & out_valid & bus.out_ready;
        // A pop on the same edge frees the slot, so a full FIFO still writes through.
        accept    = ~rst & pending & (~full | pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ack_q      <= 1'b0;
            req_prev_q <= bus.req_toggle;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pend_q <= pending & ~accept;
            // Still waiting on a held event, yet the request level reverted: a toggle was lost.
            if (pend_q && !pending) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                req_prev_q <= bus.req_toggle;
                ack_q      <= ~ack_q;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (accept && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !accept) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= bus.req_data;
        end
    end

    assign bus.ack_toggle = ack_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_valid ? mem[rd_ptr_q] : '0;
    assign bus.count      = count_q;
    assign bus.proto_err  = err_q;
endmodule

// File: tb/tb_toggle_hs_receiver.sv
// Directed and randomized bench for toggle_hs_receiver, compared every cycle against a
// queue-based reference model plus explicit constant checks at the key scenario points.
module tb_toggle_hs_receiver;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    toggle_hs_receiver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    toggle_hs_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [WIDTH-1:0] m_q[$];
    logic m_ack, m_prev, m_pend, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at one rising edge, from the inputs present at that edge.
    task automatic model_edge();
        logic pend_now, pop, acc;
        if (rst) begin
            m_q.delete();
            m_ack  = 1'b0;
            m_err  = 1'b0;
            m_pend = 1'b0;
            m_prev = bus.req_toggle;
        end else begin
            pend_now = (bus.req_toggle != m_prev);
            pop      = (m_q.size() > 0) && bus.out_ready;
            acc      = pend_now && ((m_q.size() < DEPTH) || pop);
            if (m_pend && !pend_now) m_err = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(bus.req_data);
                m_prev = bus.req_toggle;
                m_ack  = ~m_ack;
            end
            m_pend = pend_now && !acc;
        end
    endtask

    task automatic compare_model();
        chk("ack_toggle", 32'(bus.ack_toggle), 32'(m_ack));
        chk("out_valid", 32'(bus.out_valid), (m_q.size() != 0) ? 32'd1 : 32'd0);
        chk("out_data", 32'(bus.out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("count", 32'(bus.count), 32'(m_q.size()));
        chk("proto_err", 32'(bus.proto_err), 32'(m_err));
    endtask

    // Called at posedge+3: sample at posedge-2, take the edge, return at the next drive point.
    task automatic tick();
        #15;
        compare_model();
        @(posedge clk);
        model_edge();
        #3;
    endtask

    logic s_out, s_ack;

    initial begin
        rst            = 1'b1;
        bus.req_toggle = 1'b1;
        bus.req_data   = '0;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        model_edge();
        #3;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_ack", 32'(bus.ack_toggle), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);

        // Single transfer
        bus.out_ready  = 1'b1;
        bus.req_data   = 8'hA5;
        bus.req_toggle = ~bus.req_toggle;
        tick();
        chk("single_ack", 32'(bus.ack_toggle), 32'd1);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_data", 32'(bus.out_data), 32'hA5);
        tick();
        chk("single_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("single_drain_count", 32'(bus.count), 32'd0);

        // Fill to full, then a held fifth word
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.req_data   = 8'(i);
            bus.req_toggle = ~bus.req_toggle;
            tick();
            tick();
        end
        chk("fill_count", 32'(bus.count), 32'd4);
        bus.req_data   = 8'h05;
        bus.req_toggle = ~bus.req_toggle;
        repeat (3) tick();
        chk("full_hold_ack", 32'(bus.ack_toggle), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("writethru_ack", 32'(bus.ack_toggle), 32'd0);
        chk("writethru_count", 32'(bus.count), 32'd4);

        // Drain ordering
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("drain_data", 32'(bus.out_data), 32'(k));
            tick();
        end
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Protocol violation while full
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_data   = 8'($urandom);
            bus.req_toggle = ~bus.req_toggle;
            tick();
            tick();
        end
        bus.req_data   = 8'($urandom);
        bus.req_toggle = ~bus.req_toggle;
        tick();
        bus.req_toggle = ~bus.req_toggle;
        tick();
        chk("perr_set", 32'(bus.proto_err), 32'd1);
        chk("perr_count", 32'(bus.count), 32'd4);
        chk("perr_ack", 32'(bus.ack_toggle), 32'd0);
        repeat (3) tick();
        chk("perr_sticky", 32'(bus.proto_err), 32'd1);

        // Reset mid-operation with three words and a pending event
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        bus.req_toggle = ~bus.req_toggle;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ack", 32'(bus.ack_toggle), 32'd0);
        chk("mid_rst_err", 32'(bus.proto_err), 32'd0);

        // Randomized sender/consumer
        s_out = 1'b0;
        s_ack = bus.ack_toggle;
        for (int c = 0; c < 400; c++) begin
            if (bus.ack_toggle != s_ack) begin
                s_ack = bus.ack_toggle;
                s_out = 1'b0;
            end
            rst           = ($urandom_range(0, 79) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (!s_out && $urandom_range(0, 2) != 0) begin
                bus.req_data   = 8'($urandom);
                bus.req_toggle = ~bus.req_toggle;
                s_out          = 1'b1;
            end else if (s_out && $urandom_range(0, 60) == 0) begin
                bus.req_toggle = ~bus.req_toggle;
                s_out          = 1'b0;
            end
            tick();
            if (rst) begin
                s_out = 1'b0;
                s_ack = 1'b0;
            end
        end
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/toggle_hs_receiver.md
# toggle_hs_receiver

Receiving end of the two-phase (toggle) handshake: the sender flips `ReqToggle` once per transfer with `ReqData` stable, and this block returns each acceptance by flipping `AckToggle`, the toggle flip-flop output of the link. Accepted words are buffered in a small FIFO and presented downstream on a valid/ready port. Sits between a toggle-signalling producer and any valid/ready consumer in the same clock domain.

## Interface
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `clk`  input  1  single clock, all logic on posedge
- `rst`  input  1  synchronous, active-high reset
- `ReqToggle`  input  1  sender request; each level change means one new word
- `ReqData`  input  WIDTH  word; stable from the `ReqToggle` change until the matching `AckToggle` change
- `AckToggle`  output  1  acknowledge; flips once per accepted word
- `OutData`  output  WIDTH  head-of-FIFO word; 0 when `OutValid` = 0
- `OutValid`  output  1  FIFO non-empty
- `OutReady`  input  1  consumer takes head word when `OutValid` and `OutReady` are both high at a posedge
- `Count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `ProtoErr`  output  1  sticky: sender violated the handshake

## Operation
- `ReqPrev` register holds the last consumed `ReqToggle` level. Event pending = (`ReqToggle` != `ReqPrev`).
- Pop = `OutValid` & `OutReady`.
- Accept = pending & (`Count` < DEPTH | Pop).
- On Accept: write `ReqData` at the write pointer, `ReqPrev` <= `ReqToggle`, `AckToggle` <= ~`AckToggle`.
- On Pop: advance the read pointer.
- `Count` goes +1 on Accept only, −1 on Pop only, and is unchanged when both occur. Pointers wrap modulo DEPTH.
- Pending while full and no Pop: hold. `ReqPrev` and `AckToggle` do not change, so the withheld ack back-pressures the sender. The sender must keep `ReqData` stable.
- `PendQ` register holds the previous cycle's (pending & ~Accept).
- Protocol error: `PendQ` = 1 and `ReqToggle` == `ReqPrev` now, meaning the sender toggled twice without an ack. This sets `ProtoErr` = 1 and the lost event is dropped. `ProtoErr` clears only on `rst`.
- `OutData` = mem[read pointer] when `OutValid`, else 0.
- Reset (`rst` = 1 at posedge), also mid-transfer:
  - `AckToggle` = 0, `Count` = 0, `OutValid` = 0, `OutData` = 0, `ProtoErr` = 0, pointers = 0, `PendQ` = 0.
  - FIFO contents are discarded.
  - `ReqPrev` <= `ReqToggle` every reset cycle, so no spurious event on release whatever the `ReqToggle` level is.
  - While `rst` = 1, no Accept and no Pop.

## Timing
- All outputs come from registers. `OutData` and `OutValid` are a mux and compare of registered state, with no combinational path from any input.
- `ReqToggle` flips before edge N with space available:
  - `AckToggle` flips and `Count` increments after edge N.
  - When the FIFO was empty, `OutValid` = 1 and `OutData` = the word after edge N, giving 1-cycle latency.
- Full-FIFO acceptance:
  - Full with Pop at edge M: a pending event is accepted at edge M (write-through) and `Count` stays at DEPTH.
  - Full without Pop: `AckToggle` flips at the first edge with Pop.
- Sustained throughput is one word per 2 cycles, limited by the sender's req/ack round trip. Downstream drain is one word per cycle.
- Bench clocking: inputs driven `thold` after posedge, outputs sampled `tsetup` before posedge. `tsetup` = 2 ns, `thold` = 3 ns, 20 ns clock period.

## Test plan
- Reset with `ReqToggle` = 1 held through reset: after release, `AckToggle` = 0, `Count` = 0, `OutValid` = 0, and no event for 5 cycles.
- Single transfer, `OutReady` = 1:
  - Toggle `ReqToggle` with `ReqData` = 8'hA5.
  - One edge later, `AckToggle` = 1, `OutValid` = 1, `OutData` = 8'hA5.
  - Next edge: `OutValid` = 0, `Count` = 0.
- Fill, `OutReady` = 0:
  - Send 8'h01..8'h04 with the proper handshake, giving `Count` = 4.
  - A 5th toggle with 8'h05 gets no `AckToggle` change for 3 cycles.
  - Raise `OutReady` for 1 cycle: 8'h01 pops, 8'h05 is accepted at the same edge, `AckToggle` flips, `Count` stays 4.
- Drain ordering: after the fill case, `OutReady` = 1 yields 8'h02, 8'h03, 8'h04, 8'h05 on consecutive cycles, then `OutValid` = 0.
- Protocol violation:
  - With the FIFO full, toggle `ReqToggle` twice without an ack.
  - `ProtoErr` = 1 after the second toggle's edge, `Count` unchanged, `AckToggle` unchanged.
  - `ProtoErr` stays 1 until `rst`.
- Reset mid-operation:
  - Assert `rst` for 1 cycle with `Count` = 3 and a pending event.
  - Afterwards: `Count` = 0, `OutValid` = 0, `AckToggle` = 0, `ProtoErr` = 0, and the pending event is not accepted.
